display_arbiter: RTL and testbench
==================================

# display_arbiter

Owns the shared 4-digit seven-segment display and decides which requester drives it. The requesters are four service channels (time set, alarm set, stopwatch, mini-game count) plus a default channel carrying the running current time. The block arbitrates ownership with a registered one-hot grant, multiplexes and scans the digits, decodes BCD to active-low segments, blinks edit-cursor digits and overrides the output for the alarm flash. It sits between the service modules and the top-level `eSeg`/`anode` pins, replacing the ad-hoc select chain in the top level.

## Interface
Parameters:
- `SCAN_DIV`, default 2048: `clk` cycles per digit scan tick.
- `BLINK_DIV`, default 256: scan ticks per blink-phase toggle.

Ports:
- `clk`, in, 1: system clock. One clock domain; all state is on its rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `req`, in, 4: level request per service. Bit 0 is service 1 (highest priority) and bit 3 is service 4.
- `val0`..`val3`, in, 16 each: BCD digits per service; bits [15:12] are the left-most digit.
- `blink0`..`blink3`, in, 4 each: digit blink mask per service; bit 3 is the left-most digit.
- `default_val`, in, 16: current time in BCD, shown when no grant is held.
- `alarm_flash`, in, 1: alarm active; forces the flash pattern.
- `grant`, out, 4: registered one-hot grant, or 0.
- `anode`, out, 4: active-low digit enable.
- `seg`, out, 7: active-low segments, in gfedcba order.

## Operation
- **Scan divider:** counts 0..SCAN_DIV-1 and pulses `tick` on the terminal count.
- **Digit index:** `idx` (2 bits) advances on `tick`, 0→1→2→3→0. idx 0 is the right-most digit (anode 4'b1110); idx 3 is the left-most digit (anode 4'b0111).
- **Frame boundary:** the `tick` on which `idx` goes from 3 to 0.
- **Arbitration** is evaluated only at a frame boundary, so ownership never changes mid-frame:
  - If the current owner still has `req` high, it keeps the grant. Arbitration is non-preemptive.
  - Otherwise the lowest-index active `req` is granted.
  - If no `req` is active, `grant` is 0 and `default_val` is displayed.
- **Source select:** driven by the registered `grant`, never by the raw `req`.
- **BCD decode:** nibbles 0–9 map to standard glyphs. Nibbles 10–15 produce a blank digit (seg 7'b1111111).
- **Blink:** the blink phase toggles every BLINK_DIV ticks. While the phase is 1 and the owner's blink mask bit for the current digit is 1, `anode` is driven to 4'b1111 for that digit slot. `default_val` never blinks.
- **Alarm flash:** when `alarm_flash` is 1, every digit shows seg 7'b0000000 (all lit) while the phase is 0 and blank while the phase is 1. `alarm_flash` overrides both the source value and the blink mask. `grant` is unaffected.

## Timing
- **Reset values** (asserted asynchronously by `resetn`=0):
  - `grant` = 0, `anode` = 4'b1111, `seg` = 7'b1111111.
  - `idx` = 0, scan counter = 0, blink counter = 0, blink phase = 0.
- **First output:** the first `tick` after reset release drives idx 1. An active `req` is first granted at the first frame boundary, 4·SCAN_DIV cycles after reset release.
- **Output latency:** `anode` and `seg` are registered and update on the clock edge following `tick`. They reflect the new `idx` and the `grant` value in effect at that edge, so `anode` and `seg` always change together.
- **Grant latency:** a `req` asserted mid-frame is granted at the next frame boundary. The worst case is 4·SCAN_DIV cycles.
- **Owner release:** when the owner drops `req`, its grant is held until the next frame boundary. It then passes to the next requester, or to 0 if none is active.
- **Simultaneous events:** if `req` rises at the same edge as a frame boundary, it is seen at that boundary.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronously).
- **Counter widths:** $clog2 of the respective divisor. SCAN_DIV=1 and BLINK_DIV=1 are legal; with SCAN_DIV=1, `tick` is high every cycle.

## Configuration
- `DISP_BLINK_EN`
  - **Defined:** the blink counter, blink phase, blink masking and the phase-gated alarm flash are built.
  - **Undefined:** `blink0`..`blink3` are ignored, and `alarm_flash` shows all segments lit continuously with no blanking phase. The blink counter is removed.

## Structure
- **Shared package `disp_pkg`:**
  - Glyph constants: `SEG_BLANK`, `SEG_ALL`, and digits 0–9.
  - `ANODE_OFF`.
  - Service index constants `SVC_TIME`, `SVC_ALARM`, `SVC_SW`, `SVC_GAME`.
- **Sub-module `bcd_to_seg`:** combinational; input is a 4-bit nibble, output is 7-bit active-low segments. It is instantiated once and shared with the other display users in the design.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=2.
1. **Reset and default display:** reset, then release with `req`=0 and `default_val`=16'h1234.
   - `grant` stays 0.
   - The anode sequence is 1101, 1011, 0111, 1110, …, with `seg` showing 3, 2, 1, 4 respectively.
2. **Grant at frame boundary:** `req`=4'b0100 is raised at idx 1.
   - `grant` becomes 4'b0100 exactly at the next 3→0 tick.
   - `val2` digits appear from that frame onward.
3. **Non-preemption and priority:** the owner is svc 3 (bit 2); `req`=4'b0101 is raised.
   - `grant` stays 4'b0100.
   - After `req[2]` drops, `grant` becomes 4'b0001 at the next boundary.
4. **Blink:** owner svc 1, `val0`=16'h0930, `blink0`=4'b0010.
   - Digit 1 slot shows anode 4'b1111 in the phase-1 frames and a "3" glyph in the phase-0 frames.
   - The other digits are unaffected.
5. **Invalid BCD and alarm flash:** `default_val`=16'hFA00 shows blank digits 3 and 2. Raising `alarm_flash`:
   - Gives seg 7'b0000000 on all digits in phase 0 and seg 7'b1111111 in phase 1.
   - Leaves `grant` unchanged.
6. **Reset mid-frame:** pulse `resetn` low at idx 2 with an active grant.
   - Outputs immediately become `anode` 4'b1111, `seg` 7'b1111111, `grant` 0.
   - The scan restarts from idx 0.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared display constants: glyphs, anode pattern, service indices
package disp_pkg;

  // Active-low segment glyphs, bit order gfedcba
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ALL   = 7'b0000000;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;

  // All digits disabled (active-low anodes)
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Service channel positions within req/grant
  localparam int SVC_TIME  = 0;
  localparam int SVC_ALARM = 1;
  localparam int SVC_SW    = 2;
  localparam int SVC_GAME  = 3;

  // Active-low anode pattern for a digit index; idx 0 is the right-most digit
  function automatic logic [3:0] digit_anode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD nibble to active-low seven-segment glyph, blank for 10..15
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup; non-decimal codes show nothing
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - display ownership arbiter, digit scanner, blink and alarm flash (option DISP_BLINK_EN)
module display_arbiter
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 2048,
  parameter int BLINK_DIV = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic [3:0]  blink0,
  input  logic [3:0]  blink1,
  input  logic [3:0]  blink2,
  input  logic [3:0]  blink3,
  input  logic [15:0] default_val,
  input  logic        alarm_flash,
  output logic [3:0]  grant,
  output logic [3:0]  anode,
  output logic [6:0]  seg
);

  // A divisor of 1 still needs a one-bit counter that simply stays at zero
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SCAN_W-1:0] scan_cnt;
  logic              tick;
  logic [1:0]        idx;
  logic [1:0]        idx_next;
  logic              frame;
  logic [3:0]        grant_next;
  logic [15:0]       src_val;
  logic [3:0]        nibble;
  logic [6:0]        glyph;
  logic              phase_next;
  logic [3:0]        anode_next;
  logic [6:0]        seg_next;

  assign tick     = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign idx_next = tick ? idx + 2'd1 : idx;
  assign frame    = tick && (idx == 2'd3);

  // Scan divider: free-running count that wraps on the terminal value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Digit index steps once per scan tick
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx <= 2'd0;
    end else begin
      idx <= idx_next;
    end
  end

  // Non-preemptive arbitration, only at the frame boundary: a still-requesting
  // owner keeps the display, otherwise the lowest-index requester wins
  always_comb begin
    grant_next = grant;
    if (frame && ((grant & req) == 4'b0000)) begin
      casez (req)
        4'b???1: grant_next = 4'b0001;
        4'b??10: grant_next = 4'b0010;
        4'b?100: grant_next = 4'b0100;
        4'b1000: grant_next = 4'b1000;
        default: grant_next = 4'b0000;
      endcase
    end
  end

  // Grant register; outputs below follow this, never the raw requests
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant <= 4'b0000;
    end else begin
      grant <= grant_next;
    end
  end

  // Source value chosen by the grant in effect at the output update edge
  always_comb begin
    src_val = default_val;
    if (grant_next[SVC_TIME]) begin
      src_val = val0;
    end else if (grant_next[SVC_ALARM]) begin
      src_val = val1;
    end else if (grant_next[SVC_SW]) begin
      src_val = val2;
    end else if (grant_next[SVC_GAME]) begin
      src_val = val3;
    end
  end

  assign nibble = src_val[{idx_next, 2'b00} +: 4];

  bcd_to_seg u_bcd_to_seg (
    .nibble (nibble),
    .seg    (glyph)
  );

`ifdef DISP_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic               blink_wrap;
  logic [3:0]         src_blink;

  assign blink_wrap = tick && (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign phase_next = blink_wrap ? ~phase : phase;

  // Blink counter counts scan ticks; the phase flips when it wraps
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      phase     <= phase_next;
    end
  end

  // Blink mask of the owner; the current-time default never blinks
  always_comb begin
    src_blink = 4'b0000;
    if (grant_next[SVC_TIME]) begin
      src_blink = blink0;
    end else if (grant_next[SVC_ALARM]) begin
      src_blink = blink1;
    end else if (grant_next[SVC_SW]) begin
      src_blink = blink2;
    end else if (grant_next[SVC_GAME]) begin
      src_blink = blink3;
    end
  end

  // Next digit drive: alarm flash overrides value and mask; blinking digits are switched off
  always_comb begin
    anode_next = digit_anode(idx_next);
    seg_next   = glyph;
    if (alarm_flash) begin
      seg_next = phase_next ? SEG_BLANK : SEG_ALL;
    end else if (phase_next && src_blink[idx_next]) begin
      anode_next = ANODE_OFF;
    end
  end
`else
  logic unused_blink;

  assign phase_next   = 1'b0;
  assign unused_blink = ^{blink0, blink1, blink2, blink3, phase_next};

  // Next digit drive: without blinking, the alarm simply lights every segment
  always_comb begin
    anode_next = digit_anode(idx_next);
    seg_next   = glyph;
    if (alarm_flash) begin
      seg_next = SEG_ALL;
    end
  end
`endif

  // Pin registers move only on a scan tick so anode and seg always change together
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      anode <= ANODE_OFF;
      seg   <= SEG_BLANK;
    end else if (tick) begin
      anode <= anode_next;
      seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter with a tick-count reference model
module tb_display_arbiter;

  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] val0, val1, val2, val3;
  logic [3:0]  blink0, blink1, blink2, blink3;
  logic [15:0] default_val;
  logic        alarm_flash;
  logic [3:0]  grant;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int n_cmp  = 0;
  int n_fail = 0;

  display_arbiter #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .val0        (val0),
    .val1        (val1),
    .val2        (val2),
    .val3        (val3),
    .blink0      (blink0),
    .blink1      (blink1),
    .blink2      (blink2),
    .blink3      (blink3),
    .default_val (default_val),
    .alarm_flash (alarm_flash),
    .grant       (grant),
    .anode       (anode),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Standard glyphs written lit-high, then inverted for the active-low pins
  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'd0: lit = 7'h3F;
      4'd1: lit = 7'h06;
      4'd2: lit = 7'h5B;
      4'd3: lit = 7'h4F;
      4'd4: lit = 7'h66;
      4'd5: lit = 7'h6D;
      4'd6: lit = 7'h7D;
      4'd7: lit = 7'h07;
      4'd8: lit = 7'h7F;
      4'd9: lit = 7'h6F;
      default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

  // Reference model: counts clock edges since reset release; every SD-th edge is a
  // tick, the tick number fixes the digit and blink phase, and ownership is a service number
  int         mk;
  int         mt;
  int         mdig;
  int         mown;
  bit         mph;
  logic [3:0] m_grant;
  logic [3:0] m_anode;
  logic [6:0] m_seg;

  always @(posedge clk or negedge resetn) begin
    logic [15:0] v;
    logic [3:0]  bm;
    if (!resetn) begin
      mk      = 0;
      mown    = -1;
      m_grant = 4'b0000;
      m_anode = 4'b1111;
      m_seg   = 7'b1111111;
    end else begin
      mk++;
      if (mk % SD == 0) begin
        mt   = mk / SD;
        mdig = mt % 4;
        mph  = ((mt / BD) % 2) == 1;
        if (mdig == 0 && (mown < 0 || !req[mown])) begin
          mown = -1;
          for (int i = 3; i >= 0; i--) if (req[i]) mown = i;
        end
        m_grant = (mown < 0) ? 4'b0000 : (4'b0001 << mown);
        case (mown)
          0: begin v = val0; bm = blink0; end
          1: begin v = val1; bm = blink1; end
          2: begin v = val2; bm = blink2; end
          3: begin v = val3; bm = blink3; end
          default: begin v = default_val; bm = 4'b0000; end
        endcase
        m_anode = ~(4'b0001 << mdig);
        m_seg   = glyph_of(4'((v >> (4 * mdig)) & 16'hF));
`ifdef DISP_BLINK_EN
        if (alarm_flash) m_seg = mph ? 7'b1111111 : 7'b0000000;
        else if (mph && bm[mdig]) m_anode = 4'b1111;
`else
        if (alarm_flash) m_seg = 7'b0000000;
`endif
      end
    end
  end

  // Every out-of-reset cycle, all outputs must match the model
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("grant", 16'(grant), 16'(m_grant));
      check("anode", 16'(anode), 16'(m_anode));
      check("seg",   16'(seg),   16'(m_seg));
    end
  end

  // Advance to just after the next scan tick (bounded by SD edges)
  task automatic next_tick();
    do begin
      @(posedge clk);
      #1;
    end while (mk % SD != 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req = 4'b0000; alarm_flash = 1'b0;
    val0 = 16'h0000; val1 = 16'h4321; val2 = 16'h0000; val3 = 16'h9876;
    blink0 = 4'b0000; blink1 = 4'b1111; blink2 = 4'b0000; blink3 = 4'b0101;
    default_val = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_anode", 16'(anode), 16'hF);
    check("rst_seg",   16'(seg),   16'h7F);
    resetn = 1'b1;

    // Default display scan order after reset
    next_tick(); check("def_an1", 16'(anode), 16'hD); check("def_seg1", 16'(seg), 16'h30);
    next_tick(); check("def_an2", 16'(anode), 16'hB); check("def_seg2", 16'(seg), 16'h24);
    next_tick(); check("def_an3", 16'(anode), 16'h7); check("def_seg3", 16'(seg), 16'h79);
    next_tick(); check("def_an0", 16'(anode), 16'hE); check("def_seg0", 16'(seg), 16'h19);
    check("def_grant", 16'(grant), 16'h0);

    // Request raised mid-frame is granted at the next boundary
    next_tick();
    req = 4'b0100; val2 = 16'h5678;
    next_tick(); next_tick();
    check("pre_bnd_grant", 16'(grant), 16'h0);
    next_tick();
    check("bnd_grant", 16'(grant), 16'h4);
    check("bnd_seg", 16'(seg), 16'h00);

    // Non-preemption, then hand-over to the highest priority requester
    req = 4'b0101; val0 = 16'h0930; blink0 = 4'b0010;
    repeat (4) next_tick();
    check("nopreempt_grant", 16'(grant), 16'h4);
    next_tick();
    req = 4'b0001;
    next_tick(); next_tick();
    check("held_grant", 16'(grant), 16'h4);
    next_tick();
    check("handover_grant", 16'(grant), 16'h1);
    check("handover_seg", 16'(seg), 16'h40);
    next_tick();
    check("blink_dig1_an", 16'(anode), 16'hD);
    check("blink_dig1_seg", 16'(seg), 16'h30);

    // Invalid BCD digits blank, then alarm flash
    req = 4'b0000; default_val = 16'hFA00;
    repeat (3) next_tick();
    check("release_grant", 16'(grant), 16'h0);
    next_tick(); next_tick();
    check("bad_bcd_an2", 16'(anode), 16'hB);
    check("bad_bcd_seg2", 16'(seg), 16'h7F);
    next_tick();
    check("bad_bcd_seg3", 16'(seg), 16'h7F);
    req = 4'b0010; alarm_flash = 1'b1;
    next_tick();
    check("alarm_grant", 16'(grant), 16'h2);
    check("alarm_seg_ph0", 16'(seg), 16'h00);
    next_tick(); next_tick();
`ifdef DISP_BLINK_EN
    check("alarm_seg_ph1", 16'(seg), 16'h7F);
`else
    check("alarm_seg_ph1", 16'(seg), 16'h00);
`endif
    alarm_flash = 1'b0;

    // Asynchronous reset in the middle of a frame
    #2 resetn = 1'b0;
    #1;
    check("midrst_grant", 16'(grant), 16'h0);
    check("midrst_anode", 16'(anode), 16'hF);
    check("midrst_seg",   16'(seg),   16'h7F);
    #3 resetn = 1'b1;
    next_tick();
    check("restart_anode", 16'(anode), 16'hD);
    check("restart_grant", 16'(grant), 16'h0);

    // Randomized traffic at arbitrary cycle offsets
    for (int it = 0; it < 600; it++) begin
      repeat ($urandom_range(1, 6)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        val0 = 16'($urandom); val1 = 16'($urandom);
        val2 = 16'($urandom); val3 = 16'($urandom);
        blink0 = 4'($urandom); blink1 = 4'($urandom);
        blink2 = 4'($urandom); blink3 = 4'($urandom);
        default_val = 16'($urandom);
      end
      if ($urandom_range(0, 15) == 0) alarm_flash = ~alarm_flash;
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
